uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `NUM_REQ` byte sources, e.g. the RX echo path and on-board status/message generators. Each source offers bytes over a valid/ready handshake. The block accepts one byte at a time and drives the transmitter's one-cycle `transmit` strobe and `tx_byte`. It then tracks `is_transmitting` through start and completion before granting again, and a watchdog recovers if the transmitter never starts.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..8.
- `START_TIMEOUT`, 16: maximum cycles to wait for `uart_is_transmitting` to rise after the strobe; legal range 2..255.

Ports:
- Clocking: one clock; reset is asynchronous and active-low. The ports are named `clk` and `rst_n`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  requester i offers a byte.
- `req_data`  in  8*NUM_REQ  requester i byte on bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot; byte i is accepted when `req_valid[i] & req_ready[i]`.
- `uart_transmit`  out  1  one-cycle start strobe to the UART.
- `uart_tx_byte`  out  8  byte to send; held stable from the strobe until return to IDLE.
- `uart_is_transmitting`  in  1  UART busy flag.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the most recently accepted requester.
- `tx_timeout`  out  1  one-cycle pulse when the start watchdog expires.

## Operation
- FSM states: IDLE, STROBE, WAIT_START, WAIT_DONE.
- IDLE:
  - If `uart_is_transmitting`=0 and any `req_valid` is high, select winner w by round-robin, starting at `last+1` mod NUM_REQ.
  - `req_ready[w]`=1, combinationally, in the same cycle. All other `req_ready` bits stay 0.
  - On the handshake: `uart_tx_byte`←`req_data[w]`, `last`←w, `grant_id`←w, go to STROBE.
  - If `uart_is_transmitting`=1 in IDLE, no grant is issued and all `req_ready`=0.
- STROBE: `uart_transmit`=1 for exactly this cycle. Clear the watchdog counter and go to WAIT_START.
- WAIT_START:
  - If `uart_is_transmitting`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `START_TIMEOUT`, pulse `tx_timeout`, go to IDLE and drop the byte; it is not retried.
  - If `is_transmitting` rises in the same cycle the counter expires, the rise takes priority: no timeout, go to WAIT_DONE.
- WAIT_DONE: when `uart_is_transmitting`=0, go to IDLE.
- Round-robin rules:
  - `last` resets to NUM_REQ-1, so requester 0 has first priority.
  - A requester that has just been served has lowest priority for the next grant.
  - A requester may deassert `req_valid` at any time before the handshake; nothing is latched without the handshake.
- Widths: the counter is 8 bits; `grant_id` and `last` are $clog2(NUM_REQ) bits and wrap from NUM_REQ-1 to 0.

## Timing
- Reset values (asserted asynchronously, registers cleared immediately):
  - `uart_transmit`=0, `uart_tx_byte`=0x00, `busy`=0, `grant_id`=0, `tx_timeout`=0, state=IDLE, `last`=NUM_REQ-1.
  - `req_ready` is forced to 0 while `rst_n`=0.
- Latency:
  - Handshake in cycle T; `uart_transmit`=1 in T+1; WAIT_START from T+2.
  - Return to IDLE one cycle after `uart_is_transmitting` is sampled low in WAIT_DONE.
  - The next handshake is possible in that first IDLE cycle.
- Timeout: `tx_timeout` pulses START_TIMEOUT cycles after entering WAIT_START, and state is IDLE in the following cycle.
- Reset mid-operation, from any state: return to IDLE with no `uart_transmit` pulse. An in-flight byte is abandoned, and the UART is left to finish on its own.
- `uart_tx_byte` does not change between the handshake and the next handshake.

## Test plan
- Single byte:
  - Stimulus: requester 0 sends 0x41; the UART model raises `is_transmitting` 2 cycles after the strobe and holds it 100 cycles.
  - Response: one `uart_transmit` pulse with `uart_tx_byte`=0x41, `grant_id`=0, `busy` high throughout, `req_ready[0]` high for exactly one cycle.
- Fairness:
  - Stimulus: NUM_REQ=3, all requesters continuously valid with 0x10/0x20/0x30.
  - Response: transmitted sequence 0x10,0x20,0x30,0x10,... with no requester served twice in a row.
- Timeout:
  - Stimulus: `is_transmitting` held at 0 after a strobe.
  - Response: `tx_timeout` is a 1-cycle pulse exactly 16 cycles after WAIT_START entry, then IDLE. The next valid byte is granted normally to the next requester in rotation.
- Boundary:
  - Stimulus: `is_transmitting` rises on the cycle the counter expires.
  - Response: no `tx_timeout`; the FSM enters WAIT_DONE.
- UART busy in IDLE:
  - Stimulus: `uart_is_transmitting`=1 while `req_valid`=1.
  - Response: all `req_ready`=0 until `is_transmitting` drops, then the grant occurs the same cycle.
- Reset mid-WAIT_DONE:
  - Stimulus: `rst_n` pulsed low for 3 cycles.
  - Response: all outputs at reset values immediately. After release, requester 0 has priority and no spurious `uart_transmit` pulse occurs.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// A start watchdog drops the byte if the transmitter never reports busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_transmit,
  output logic [7:0]                 uart_tx_byte,
  input  logic                       uart_is_transmitting,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_timeout
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_RST    = IDW'(NUM_REQ - 1);
  localparam logic [7:0]     TIMEOUT_CNT = 8'(START_TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STROBE     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_nx;
  logic [IDW-1:0]     last_r, last_nx;
  logic [IDW-1:0]     grant_r, grant_nx;
  logic [IDW-1:0]     win_s;
  logic [7:0]         cnt_r, cnt_nx, cnt_inc_s;
  logic [7:0]         byte_r, byte_nx;
  logic               transmit_r, transmit_nx;
  logic               timeout_r, timeout_nx;
  logic               busy_r;
  logic               grant_ok_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [7:0]         data_a [NUM_REQ];

  // (base + k) mod NUM_REQ for 1 <= k <= NUM_REQ, so one subtraction suffices
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_a[g] = req_data[8*g +: 8];
  end

  // Winner search: scanning from lowest to highest priority lets the last hit win
  always_comb begin
    win_s = last_r;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[rr_idx(last_r, k)]) begin
        win_s = rr_idx(last_r, k);
      end else begin
        win_s = win_s;
      end
    end
  end

  assign grant_ok_s = (state_r == IDLE) && !uart_is_transmitting && (|req_valid);
  assign ready_s    = grant_ok_s ? (ONE_HOT0 << win_s) : {NUM_REQ{1'b0}};
  assign req_ready  = rst_n ? ready_s : {NUM_REQ{1'b0}};
  assign cnt_inc_s  = cnt_r + 8'd1;

  // Next-state and next-register-value logic
  always_comb begin
    state_nx    = state_r;
    last_nx     = last_r;
    grant_nx    = grant_r;
    byte_nx     = byte_r;
    cnt_nx      = cnt_r;
    transmit_nx = 1'b0;
    timeout_nx  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_ok_s) begin
          byte_nx     = data_a[win_s];
          last_nx     = win_s;
          grant_nx    = win_s;
          transmit_nx = 1'b1;
          state_nx    = STROBE;
        end else begin
          state_nx = IDLE;
        end
      end
      STROBE: begin
        cnt_nx   = 8'd0;
        state_nx = WAIT_START;
      end
      WAIT_START: begin
        if (uart_is_transmitting) begin
          state_nx = WAIT_DONE;
        end else if (cnt_inc_s == TIMEOUT_CNT) begin
          cnt_nx     = cnt_inc_s;
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt_inc_s;
        end
      end
      WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_r     <= LAST_RST;
      grant_r    <= {IDW{1'b0}};
      byte_r     <= 8'h00;
      cnt_r      <= 8'd0;
      transmit_r <= 1'b0;
      timeout_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      last_r     <= last_nx;
      grant_r    <= grant_nx;
      byte_r     <= byte_nx;
      cnt_r      <= cnt_nx;
      transmit_r <= transmit_nx;
      timeout_r  <= timeout_nx;
      busy_r     <= (state_nx != IDLE);
    end
  end

  assign uart_transmit = transmit_r;
  assign uart_tx_byte  = byte_r;
  assign grant_id      = grant_r;
  assign tx_timeout    = timeout_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter; the reference model picks
// winners arithmetically and predicts timing from the UART rise/hold delays.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           uart_transmit;
  logic [7:0]     uart_tx_byte;
  logic           uart_is_transmitting = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           tx_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int last_m = N - 1;
  logic [7:0] byte_m = 8'h00;
  int grant_m = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .busy(busy), .grant_id(grant_id),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Called at a negedge with the DUT idle; d = cycles after the strobe at which the
  // UART rises (d > TO means never), h = cycles it stays high.
  task automatic do_round(input logic [N-1:0] m, input logic [8*N-1:0] dat,
                          input int d, input int h);
    int w;
    bit timed;
    int endc;
    w = rr_pick(m, last_m);
    req_valid = m;
    req_data  = dat;
    #1;
    check_val("ready_grant", req_ready, 32'(1 << w));
    @(negedge clk);
    last_m  = w;
    grant_m = w;
    byte_m  = dat[8*w +: 8];
    check_val("strobe", uart_transmit, 1);
    check_val("tx_byte", uart_tx_byte, byte_m);
    check_val("grant_id", grant_id, grant_m);
    check_val("busy_strobe", busy, 1);
    uart_is_transmitting = 1'b0;
    timed = (d > TO);
    endc  = timed ? TO + 1 : d + h + 1;
    for (int c = 1; c <= endc; c++) begin
      @(negedge clk);
      check_val("no_strobe", uart_transmit, 0);
      check_val("timeout", tx_timeout, (timed && c == TO + 1) ? 1 : 0);
      check_val("busy", busy, (c < endc) ? 1 : 0);
      check_val("byte_hold", uart_tx_byte, byte_m);
      uart_is_transmitting = !timed && c >= d && c < d + h;
      req_valid = N'($urandom);
      #1;
      if (c < endc) check_val("ready_busy", req_ready, 0);
    end
  endtask

  initial begin
    logic [N-1:0] m;
    logic [8*N-1:0] dat;
    int w;

    // Reset state with all requesters valid: ready must stay low
    req_valid = '1;
    @(negedge clk);
    check_val("rst_transmit", uart_transmit, 0);
    check_val("rst_byte", uart_tx_byte, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_grant", grant_id, 0);
    check_val("rst_timeout", tx_timeout, 0);
    check_val("rst_ready", req_ready, 0);
    rst_n = 1'b1;

    // Single byte from requester 0
    do_round(3'b001, {8'h00, 8'h00, 8'h41}, 2, 100);

    // Fairness: everyone valid, strict rotation
    for (int i = 0; i < 6; i++) do_round(3'b111, {8'h30, 8'h20, 8'h10}, 2, 3);

    // Timeout, then the next requester in rotation is served normally
    do_round(3'b111, {8'h33, 8'h22, 8'h11}, TO + 5, 0);
    do_round(3'b111, {8'h36, 8'h25, 8'h14}, 3, 2);
    // Boundary: rise on the expiry cycle wins; one cycle later is a timeout
    do_round(3'b111, {8'h9c, 8'h9b, 8'h9a}, TO, 4);
    do_round(3'b111, {8'h9f, 8'h9e, 8'h9d}, TO + 1, 0);

    // UART busy in IDLE: no grant until it drops, then grant in that cycle
    uart_is_transmitting = 1'b1;
    req_valid = 3'b110;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("ready_uart_busy", req_ready, 0);
      @(negedge clk);
    end
    uart_is_transmitting = 1'b0;
    do_round(3'b110, {8'h77, 8'h66, 8'h55}, 1, 1);

    // Reset in the middle of WAIT_DONE
    m   = 3'b111;
    dat = {8'hc3, 8'hb2, 8'ha1};
    w   = rr_pick(m, last_m);
    req_valid = m;
    req_data  = dat;
    #1;
    check_val("ready_pre_rst", req_ready, 32'(1 << w));
    @(negedge clk);
    check_val("strobe_pre_rst", uart_transmit, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      uart_is_transmitting = (c >= 2);
    end
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_byte", uart_tx_byte, 0);
    check_val("midrst_grant", grant_id, 0);
    check_val("midrst_ready", req_ready, 0);
    check_val("midrst_timeout", tx_timeout, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("midrst_transmit", uart_transmit, 0);
    end
    rst_n = 1'b1;
    uart_is_transmitting = 1'b0;
    last_m  = N - 1;
    byte_m  = 8'h00;
    grant_m = 0;
    #1;
    check_val("post_rst_transmit", uart_transmit, 0);
    check_val("post_rst_ready", req_ready, 1);
    do_round(3'b111, {8'h03, 8'h02, 8'h01}, 2, 3);

    // Randomized rounds
    for (int i = 0; i < 40; i++) begin
      m   = N'($urandom_range(1, (1 << N) - 1));
      dat = {8'($urandom), 8'($urandom), 8'($urandom)};
      do_round(m, dat, int'($urandom_range(1, TO + 4)), int'($urandom_range(1, 8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
